// File: rtl/vga_text_pkg.sv
// Shared constants and helpers for the VGA text-mode pixel path.
package vga_text_pkg;

  // Character codes whose 9th column repeats the glyph's last bit.
  localparam logic [7:0] LINE_GFX_LO = 8'hC0;
  localparam logic [7:0] LINE_GFX_HI = 8'hDF;

  // Default cell geometry.
  localparam int unsigned DEF_GLYPH_W = 8;
  localparam int unsigned DEF_CELL_W  = 9;
  localparam int unsigned DEF_ROWS    = 16;

  // Value of every extension column beyond the glyph width.
  function automatic logic ext_col_bit(input logic [7:0] ascii, input logic glyph_lsb);
    return ((ascii >= LINE_GFX_LO) && (ascii <= LINE_GFX_HI)) ? glyph_lsb : 1'b0;
  endfunction

endpackage

// File: rtl/blink_timer.sv
// Frame counter producing the blink phase; phase 1 means blinking cells are visible.
module blink_timer #(
  parameter int unsigned BLINK_FRAMES = 16
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic frame_stb_i,
  output logic phase_o
);

  localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_phase;

  // Count frames; toggle the phase each time the half-period wraps.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else if (frame_stb_i) begin
      if (r_cnt == LAST) begin
        r_cnt   <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign phase_o = r_phase;

endmodule

// File: rtl/text_cell_pixel_gen.sv
// Text-mode cell serialiser: ROM address issue, glyph-row shift-out, blink and cursor.
module text_cell_pixel_gen
  import vga_text_pkg::*;
#(
  parameter int unsigned GLYPH_W      = DEF_GLYPH_W,
  parameter int unsigned CELL_W       = DEF_CELL_W,
  parameter int unsigned ROWS         = DEF_ROWS,
  parameter int unsigned COLOR_W      = 4,
  parameter int unsigned BLINK_FRAMES = 16,
  parameter int unsigned CUR_START    = 14,
  parameter int unsigned CUR_END      = 15,
  localparam int unsigned ROW_W       = $clog2(ROWS)
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 en_i,
  input  logic [7:0]           ascii_i,
  input  logic [ROW_W-1:0]     glyph_row_i,
  input  logic [COLOR_W-1:0]   fg_i,
  input  logic [COLOR_W-1:0]   bg_i,
  input  logic                 blink_i,
  input  logic                 cursor_i,
  input  logic                 frame_stb_i,
  output logic                 rd_stb_o,
  output logic [8+ROW_W-1:0]   addr_o,
  input  logic [GLYPH_W-1:0]   din_i,
  output logic                 pixel_vld_o,
  output logic                 pixel_o,
  output logic [COLOR_W-1:0]   color_o
);

  localparam int unsigned CNT_W = (CELL_W > 1) ? $clog2(CELL_W) : 1;
  localparam int unsigned EXT_W = CELL_W - GLYPH_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CELL_W - 1);

  // Stage 1: attributes waiting for the ROM word.
  logic               r_ld_pend;
  logic [7:0]         r_s1_ascii;
  logic [ROW_W-1:0]   r_s1_row;
  logic [COLOR_W-1:0] r_s1_fg;
  logic [COLOR_W-1:0] r_s1_bg;
  logic               r_s1_blink;
  logic               r_s1_cursor;

  // Stage 2: cell being shifted out.
  logic [CELL_W-1:0]  r_shift;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_vld;
  logic [ROW_W-1:0]   r_s2_row;
  logic [COLOR_W-1:0] r_s2_fg;
  logic [COLOR_W-1:0] r_s2_bg;
  logic               r_s2_blink;
  logic               r_s2_cursor;

  logic               w_phase;
  logic               w_ext_bit;
  logic [CELL_W-1:0]  w_load_word;
  logic               w_in_band;
  logic               w_vis;

  assign rd_stb_o = en_i;
  assign addr_o   = {ascii_i, glyph_row_i};

  blink_timer #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink_timer (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .frame_stb_i(frame_stb_i),
    .phase_o    (w_phase)
  );

  // Capture cell attributes alongside the ROM address edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ld_pend   <= 1'b0;
      r_s1_ascii  <= '0;
      r_s1_row    <= '0;
      r_s1_fg     <= '0;
      r_s1_bg     <= '0;
      r_s1_blink  <= 1'b0;
      r_s1_cursor <= 1'b0;
    end else begin
      r_ld_pend <= en_i;
      if (en_i) begin
        r_s1_ascii  <= ascii_i;
        r_s1_row    <= glyph_row_i;
        r_s1_fg     <= fg_i;
        r_s1_bg     <= bg_i;
        r_s1_blink  <= blink_i;
        r_s1_cursor <= cursor_i;
      end
    end
  end

  // Build the cell word: glyph bits MSB first, then the extension columns.
  always_comb begin
    w_ext_bit   = ext_col_bit(r_s1_ascii, din_i[0]);
    w_load_word = '0;
    w_load_word[CELL_W-1 -: GLYPH_W] = din_i;
    for (int i = 0; i < int'(EXT_W); i++) begin
      w_load_word[i] = w_ext_bit;
    end
  end

  // Load a new cell (overriding any current one) or shift out the current one.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_shift     <= '0;
      r_cnt       <= '0;
      r_vld       <= 1'b0;
      r_s2_row    <= '0;
      r_s2_fg     <= '0;
      r_s2_bg     <= '0;
      r_s2_blink  <= 1'b0;
      r_s2_cursor <= 1'b0;
    end else if (r_ld_pend) begin
      r_shift     <= w_load_word;
      r_cnt       <= CNT_LAST;
      r_vld       <= 1'b1;
      r_s2_row    <= r_s1_row;
      r_s2_fg     <= r_s1_fg;
      r_s2_bg     <= r_s1_bg;
      r_s2_blink  <= r_s1_blink;
      r_s2_cursor <= r_s1_cursor;
    end else if (r_vld) begin
      if (r_cnt == '0) begin
        r_vld <= 1'b0;
      end else begin
        r_shift <= r_shift << 1;
        r_cnt   <= r_cnt - 1'b1;
      end
    end
  end

  // Pixel decision; blink phase is sampled live, not latched per cell.
  always_comb begin
    w_in_band = (32'(r_s2_row) >= CUR_START) && (32'(r_s2_row) <= CUR_END);
    w_vis     = r_shift[CELL_W-1] & ~(r_s2_blink & ~w_phase);
    if (r_s2_cursor && w_phase && w_in_band) begin
      w_vis = ~w_vis;
    end
    pixel_vld_o = r_vld;
    pixel_o     = r_vld & w_vis;
    color_o     = r_vld ? (w_vis ? r_s2_fg : r_s2_bg) : '0;
  end

endmodule

// File: tb/tb_text_cell_pixel_gen.sv
// Randomised bench for text_cell_pixel_gen with a cell-timeline reference model.
module tb_text_cell_pixel_gen;

  localparam int CELL = 9;
  localparam int HALF = 16;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        en_i = 1'b0;
  logic [7:0]  ascii_i = '0;
  logic [3:0]  glyph_row_i = '0;
  logic [3:0]  fg_i = '0;
  logic [3:0]  bg_i = '0;
  logic        blink_i = 1'b0;
  logic        cursor_i = 1'b0;
  logic        frame_stb_i = 1'b0;
  logic        rd_stb_o;
  logic [11:0] addr_o;
  logic [7:0]  din_i;
  logic        pixel_vld_o;
  logic        pixel_o;
  logic [3:0]  color_o;

  text_cell_pixel_gen #(
    .GLYPH_W(8), .CELL_W(9), .ROWS(16), .COLOR_W(4),
    .BLINK_FRAMES(16), .CUR_START(14), .CUR_END(15)
  ) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .en_i       (en_i),
    .ascii_i    (ascii_i),
    .glyph_row_i(glyph_row_i),
    .fg_i       (fg_i),
    .bg_i       (bg_i),
    .blink_i    (blink_i),
    .cursor_i   (cursor_i),
    .frame_stb_i(frame_stb_i),
    .rd_stb_o   (rd_stb_o),
    .addr_o     (addr_o),
    .din_i      (din_i),
    .pixel_vld_o(pixel_vld_o),
    .pixel_o    (pixel_o),
    .color_o    (color_o)
  );

  always #5 clk_i = ~clk_i;

  // Character ROM owned by the bench: registered read, data valid the cycle after.
  logic [7:0] rom [4096];
  always @(posedge clk_i) if (rd_stb_o) din_i <= rom[addr_o];

  typedef struct {
    int         start;
    logic [7:0] ascii;
    logic [3:0] row;
    logic [3:0] fg;
    logic [3:0] bg;
    logic       blink;
    logic       cursor;
  } cell_t;

  cell_t cells[$];
  int    cyc = 0;
  int    pulses = 0;
  int    n_cmp = 0;
  int    n_err = 0;

  function automatic cell_t mk(input logic [7:0] a, input logic [3:0] r, input logic [3:0] f,
                               input logic [3:0] b, input logic bl, input logic cu);
    cell_t c;
    c.start = 0; c.ascii = a; c.row = r; c.fg = f; c.bg = b; c.blink = bl; c.cursor = cu;
    return c;
  endfunction

  function automatic cell_t rand_cell();
    logic [7:0] a;
    a = ($urandom % 2 == 0) ? 8'(8'hC0 + $urandom_range(0, 31)) : 8'($urandom);
    return mk(a, 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
  endfunction

  // Expected {pixel, colour} of pixel k of cell c after pc frame pulses.
  function automatic logic [4:0] model_px(input cell_t c, input int k, input int pc);
    logic [7:0] w;
    logic g, ph, vis;
    w = rom[{c.ascii, c.row}];
    if (k < 8) g = w[7-k];
    else       g = (c.ascii >= 8'hC0 && c.ascii <= 8'hDF) ? w[0] : 1'b0;
    ph  = ((pc / HALF) % 2) == 0;
    vis = g && !(c.blink && !ph);
    if (c.cursor && ph && c.row >= 4'd14 && c.row <= 4'd15) vis = !vis;
    return {vis, vis ? c.fg : c.bg};
  endfunction

  // One cycle: check outputs against the timeline model, then drive this cycle's inputs.
  task automatic tick(input string nm, input logic en, input cell_t c, input logic frm);
    logic       e_vld;
    logic [4:0] e_px;
    int         k;
    @(negedge clk_i);
    cyc++;
    e_vld = 1'b0;
    e_px  = '0;
    for (int j = cells.size() - 1; j >= 0; j--) begin
      if (cells[j].start + 2 <= cyc) begin
        k = cyc - (cells[j].start + 2);
        if (k < CELL) begin
          e_vld = 1'b1;
          e_px  = model_px(cells[j], k, pulses);
        end
        break;
      end
    end
    n_cmp++;
    if (pixel_vld_o !== e_vld) begin
      n_err++;
      $display("FAIL %s vld cyc=%0d got %0b exp %0b", nm, cyc, pixel_vld_o, e_vld);
    end
    if (e_vld) begin
      n_cmp++;
      if ({pixel_o, color_o} !== e_px) begin
        n_err++;
        $display("FAIL %s pixel cyc=%0d got pix=%0b col=%h exp pix=%0b col=%h",
                 nm, cyc, pixel_o, color_o, e_px[4], e_px[3:0]);
      end
    end
    en_i = en; ascii_i = c.ascii; glyph_row_i = c.row; fg_i = c.fg; bg_i = c.bg;
    blink_i = c.blink; cursor_i = c.cursor; frame_stb_i = frm;
    if (en) begin
      c.start = cyc;
      cells.push_back(c);
    end
    if (frm) pulses++;
  endtask

  task automatic idle(input string nm, input int n);
    cell_t z;
    z = mk(8'h00, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    repeat (n) tick(nm, 1'b0, z, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_n_i = 1'b0; en_i = 1'b0; frame_stb_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    cells.delete();
    pulses = 0;
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    rst_n_i = 1'b0; en_i = 1'b0;
    #1;
    n_cmp++;
    if ({pixel_vld_o, pixel_o, color_o} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_outputs got vld=%0b pix=%0b col=%h exp 0", pixel_vld_o, pixel_o,
               color_o);
    end
    en_i = 1'b1; ascii_i = 8'hA5; glyph_row_i = 4'h3;
    #1;
    n_cmp++;
    if (rd_stb_o !== 1'b1 || addr_o !== 12'hA53) begin
      n_err++;
      $display("FAIL reset_addr got rd=%0b addr=%h exp rd=1 addr=a53", rd_stb_o, addr_o);
    end
    en_i = 1'b0;
    #1;
    n_cmp++;
    if (rd_stb_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_rdstb got %0b exp 0", rd_stb_o);
    end
    do_reset();
  endtask

  task automatic test_glyphs();
    do_reset();
    tick("glyph_b2", 1'b1, mk(8'd178, 4'd1, 4'hF, 4'h1, 1'b0, 1'b0), 1'b0);
    idle("glyph_b2", 12);
    tick("glyph_db", 1'b1, mk(8'd219, 4'd0, 4'h7, 4'h2, 1'b0, 1'b0), 1'b0);
    idle("glyph_db", 12);
  endtask

  task automatic test_back_to_back();
    do_reset();
    tick("b2b", 1'b1, mk(8'd219, 4'd0, 4'hC, 4'h3, 1'b0, 1'b0), 1'b0);
    idle("b2b", 8);
    tick("b2b", 1'b1, mk(8'd178, 4'd1, 4'hF, 4'h1, 1'b0, 1'b0), 1'b0);
    idle("b2b", 8);
    for (int i = 0; i < 20; i++) begin
      tick("stream", 1'b1, rand_cell(), 1'b0);
      idle("stream", 8);
    end
    idle("stream", 4);
  endtask

  task automatic test_cursor();
    do_reset();
    tick("cursor14", 1'b1, mk(8'h20, 4'd14, 4'hE, 4'h6, 1'b0, 1'b1), 1'b0);
    idle("cursor14", 10);
    tick("cursor13", 1'b1, mk(8'h20, 4'd13, 4'hE, 4'h6, 1'b0, 1'b1), 1'b0);
    idle("cursor13", 10);
  endtask

  task automatic test_blink();
    cell_t z;
    z = mk(8'h00, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    do_reset();
    for (int p = 0; p < 34; p++) begin
      tick("blink", 1'b1, mk(8'd219, 4'd0, 4'hA, 4'h5, 1'b1, 1'b0), 1'b0);
      idle("blink", 11);
      tick("blink", 1'b0, z, 1'b1);
    end
  endtask

  task automatic test_random_truncate();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      tick("random", ($urandom % 5 == 0), rand_cell(), ($urandom % 6 == 0));
    end
    for (int i = 0; i < 4; i++) tick("consec", 1'b1, rand_cell(), 1'b0);
    idle("consec", 12);
  endtask

  task automatic test_reset_mid_cell();
    cell_t z;
    z = mk(8'h00, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    do_reset();
    repeat (16) tick("mid_pre", 1'b0, z, 1'b1);
    tick("mid_cell", 1'b1, mk(8'd219, 4'd0, 4'h9, 4'h4, 1'b0, 1'b0), 1'b0);
    idle("mid_cell", 6);
    #2 rst_n_i = 1'b0;
    #1;
    n_cmp++;
    if ({pixel_vld_o, pixel_o, color_o} !== 6'b0) begin
      n_err++;
      $display("FAIL mid_reset got vld=%0b pix=%0b col=%h exp 0", pixel_vld_o, pixel_o, color_o);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    cells.delete();
    pulses = 0;
    // A blinking cell is visible only if the phase came back as 1.
    tick("mid_after", 1'b1, mk(8'd219, 4'd0, 4'hB, 4'h2, 1'b1, 1'b0), 1'b0);
    idle("mid_after", 11);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
    rom[{8'd178, 4'd1}]  = 8'b0111_0111;
    rom[{8'd219, 4'd0}]  = 8'b1111_1111;
    rom[{8'h20, 4'd13}]  = 8'h00;
    rom[{8'h20, 4'd14}]  = 8'h00;
    test_reset();
    test_glyphs();
    test_back_to_back();
    test_cursor();
    test_blink();
    test_random_truncate();
    test_reset_mid_cell();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/text_cell_pixel_gen.md
# text_cell_pixel_gen

Parametrised, pipelined text-mode pixel generator for the VGA subsystem. Per character cell it reads one glyph row from the character ROM and serialises it into a CELL_W-pixel run, including the line-graphics 9th-column rule. It also applies foreground/background colour, per-cell blink and a cursor band. It sits between the text-buffer/timing logic and the DAC palette stage, and streams seamlessly when cells are issued every CELL_W cycles.

## Interface
- GLYPH_W, 8: glyph bits per ROM word.
- CELL_W, 9: pixels per cell; must be ≥ GLYPH_W.
- ROWS, 16: glyph rows per character; ROW_W = $clog2(ROWS).
- COLOR_W, 4: colour index width.
- BLINK_FRAMES, 16: frames per blink half-period.
- CUR_START, 14 and CUR_END, 15: cursor band rows, inclusive.
- clk_i  in  1  pixel clock.
- rst_n_i  in  1  asynchronous, active-low reset.
- en_i  in  1  cell load strobe; one cycle per cell.
- ascii_i  in  8  character code.
- glyph_row_i  in  ROW_W  row within the glyph.
- fg_i, bg_i  in  COLOR_W each  cell colours.
- blink_i  in  1  cell blink attribute.
- cursor_i  in  1  cursor is on this cell.
- frame_stb_i  in  1  one-cycle pulse per frame.
- rd_stb_o  out  1  ROM read enable; equals en_i (combinational).
- addr_o  out  8+ROW_W  ROM address {ascii_i, glyph_row_i} (combinational).
- din_i  in  GLYPH_W  ROM data; valid in the cycle after the read edge.
- pixel_vld_o  out  1  pixel_o and color_o are valid.
- pixel_o  out  1  final foreground/background decision.
- color_o  out  COLOR_W  selected colour index.

## Operation
- Stage 0 (edge E0, en_i=1): the ROM registers addr_o. The block captures ascii, row, fg, bg, blink and cursor into stage-1 registers. It also sets ld_pend.
- Stage 1 (edge E1, ld_pend=1): din_i is loaded into a CELL_W shift register and the stage-1 attributes move to stage 2. The pixel counter is set to CELL_W-1 and pixel_vld_o is set to 1.
- Shift-register contents are MSB first: din_i[GLYPH_W-1:0], followed by CELL_W-GLYPH_W extension bits.
- Each extension bit equals din_i[0] when the code is in the line-graphics range 0xC0..0xDF; otherwise it is 0.
- Each subsequent edge shifts the register left by one and decrements the counter. At counter==0, pixel_vld_o clears on the next edge, unless a new load occurs on that edge.
- A load at E1 always overrides any in-progress cell, which is truncated. No error is flagged.
- Blink timer: a counter increments on each frame_stb_i. At BLINK_FRAMES-1 it wraps to 0 and toggles the phase bit. The phase resets to 1 (visible).
- Pixel decision, where g is the current shift-register MSB:
  - vis = g & ~(blink & ~phase).
  - If cursor is set, phase=1 and the row is within [CUR_START, CUR_END], then vis is inverted.
- Outputs: pixel_o = vis; color_o = vis ? fg : bg.
- Outputs are combinational from stage-2 registers. All state is registered.

## Timing
- Reset (asynchronous, active-low) clears all of the following:
  - pixel_vld_o = 0, pixel_o = 0, color_o = 0.
  - Shift register, pixel counter and ld_pend.
  - Blink counter = 0 and phase = 1.
- rd_stb_o and addr_o are combinational and not gated by reset.
- Latency: en_i sampled at E0 gives the first valid pixel in the cycle after E1, i.e. two edges after en_i.
- Throughput: en_i every CELL_W cycles produces an unbroken pixel_vld_o stream. en_i at a shorter spacing truncates the prior cell.
- en_i held for consecutive cycles loads each cycle; only the last load survives.
- frame_stb_i coincident with a load: the phase change takes effect on the following cycle's pixels. Phase is not latched per cell.
- Reset mid-cell: pixel_vld_o drops immediately. The next cell still needs a full E0/E1 sequence.
- glyph_row_i ≥ ROWS is passed to addr_o unchanged; the ROM's contents define the result.

## Structure
- Package vga_text_pkg holds:
  - LINE_GFX_LO=8'hC0 and LINE_GFX_HI=8'hDF.
  - Default geometry constants (GLYPH_W, CELL_W, ROWS).
  - A function for the 9th-column rule.
- Sub-module blink_timer, parametrised by BLINK_FRAMES, takes clk_i, rst_n_i and frame_stb_i and outputs phase_o.

## Test plan
- Code 178 (0xB2), row 1, ROM word 01110111, fg=F, bg=1 → pixels 0,1,1,1,0,1,1,1,0 with colours 1,F,F,F,1,F,F,F,1. pixel_vld_o is high for exactly 9 cycles starting two edges after en_i.
- Code 219 (0xDB), row 0, ROM word 11111111 → nine 1s; the 9th pixel duplicates bit 0.
- Code 219 then 178, with en_i 9 cycles apart → 18 contiguous valid pixels with no gap.
- blink_i=1 on code 219 → visible for the first 16 frame_stb_i pulses, then all bg for the next 16. Phase toggles exactly at the 16th pulse.
- cursor_i=1, row 14, code 0x20 (ROM word 0) → all pixels fg while phase=1. With row 13 → all bg.
- Reset asserted on pixel 4 of a cell → pixel_vld_o is 0 asynchronously and the blink phase is 1. A fresh en_i after release yields a complete 9-pixel cell.
